// File: rtl/lc3b_fetch_stage_if.sv
// Instruction memory read/resp bus between the fetch stage and instruction memory.
interface lc3b_fetch_stage_if;
   logic        imem_read;
   logic [15:0] imem_address;
   logic [15:0] imem_rdata;
   logic        imem_resp;

   modport master (
      output imem_read,
      output imem_address,
      input  imem_rdata,
      input  imem_resp
   );

   modport slave (
      input  imem_read,
      input  imem_address,
      output imem_rdata,
      output imem_resp
   );
endinterface

// File: rtl/lc3b_fetch_stage.sv
// LC-3b fetch stage: owns the PC, issues one instruction read at a time, holds the
// fetched instruction for decode and squashes wrong-path fetches on redirect.
module lc3b_fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   lc3b_fetch_stage_if.master         imem,
   input  logic                       stall,
   input  logic                       redirect,
   input  logic [15:0]                redirect_pc,
   output logic                       if_valid,
   output logic [15:0]                if_ir,
   output logic [15:0]                if_pc,
   output logic [15:0]                if_pc_plus2,
   output logic [3:0]                 if_opcode
);

   typedef enum logic [1:0] {StStart, StFetch, StDiscard, StHold} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] pending_pc_q, pending_pc_d;
   logic [15:0] if_ir_q, if_ir_d;
   logic [15:0] if_pc_q, if_pc_d;
   logic        if_valid_q, if_valid_d;
   logic        read;

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StStart;
         pc_q         <= RESET_PC;
         pending_pc_q <= RESET_PC;
         if_ir_q      <= 16'h0000;
         if_pc_q      <= 16'h0000;
         if_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         if_ir_q      <= if_ir_d;
         if_pc_q      <= if_pc_d;
         if_valid_q   <= if_valid_d;
      end
   end

   // Next-state and read-request logic.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      if_ir_d      = if_ir_q;
      if_pc_d      = if_pc_q;
      if_valid_d   = if_valid_q;
      read         = 1'b0;
      unique case (state_q)
         StStart: begin
            state_d = StFetch;
         end
         StFetch: begin
            read = 1'b1;
            if (imem.imem_resp) begin
               if (redirect) begin
                  // Wrong-path data: drop it and refetch at the target.
                  pc_d = redirect_pc;
               end else begin
                  if_ir_d    = imem.imem_rdata;
                  if_pc_d    = pc_q;
                  if_valid_d = 1'b1;
                  pc_d       = pc_q + 16'd2;
                  state_d    = StHold;
               end
            end else if (redirect) begin
               // Address must stay stable until resp, so park the target.
               pending_pc_d = redirect_pc;
               state_d      = StDiscard;
            end
         end
         StDiscard: begin
            read = 1'b1;
            if (redirect) begin
               pending_pc_d = redirect_pc;
            end
            if (imem.imem_resp) begin
               pc_d    = redirect ? redirect_pc : pending_pc_q;
               state_d = StFetch;
            end
         end
         StHold: begin
            if (redirect) begin
               if_valid_d = 1'b0;
               pc_d       = redirect_pc;
               state_d    = StFetch;
            end else if (!stall) begin
               if_valid_d = 1'b0;
               state_d    = StFetch;
            end
         end
         default: begin
            state_d = StStart;
         end
      endcase
   end

   assign imem.imem_read    = read;
   assign imem.imem_address = pc_q;
   assign if_valid          = if_valid_q;
   assign if_ir             = if_ir_q;
   assign if_pc             = if_pc_q;
   assign if_pc_plus2       = if_pc_q + 16'd2;
   assign if_opcode         = if_ir_q[15:12];

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Directed testbench for lc3b_fetch_stage with a variable-latency instruction memory.
module tb_lc3b_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        if_valid;
   logic [15:0] if_ir;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus2;
   logic [3:0]  if_opcode;
   logic        w_valid;
   logic [15:0] w_ir;
   logic [15:0] w_pc;
   logic [15:0] w_pc_plus2;
   logic [3:0]  w_opcode;
   logic        stall_w;
   logic        redirect_w;
   int          lat;
   int          cnt;
   int          checks;
   int          errors;

   lc3b_fetch_stage_if bus ();
   lc3b_fetch_stage_if bus_w ();

   lc3b_fetch_stage u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (bus),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_ir       (if_ir),
      .if_pc       (if_pc),
      .if_pc_plus2 (if_pc_plus2),
      .if_opcode   (if_opcode)
   );

   lc3b_fetch_stage #(.RESET_PC(16'hFFFE)) u_dut_w (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (bus_w),
      .stall       (stall_w),
      .redirect    (redirect_w),
      .redirect_pc (16'h0000),
      .if_valid    (w_valid),
      .if_ir       (w_ir),
      .if_pc       (w_pc),
      .if_pc_plus2 (w_pc_plus2),
      .if_opcode   (w_opcode)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: mem_word = 16'h1234;
         16'h0002: mem_word = 16'h5678;
         16'h0004: mem_word = 16'hA004;
         16'h0100: mem_word = 16'h2100;
         16'h0200: mem_word = 16'h3200;
         default:  mem_word = {4'hE, a[11:0]};
      endcase
   endfunction

   // Memory responds in the lat-th cycle of a request.
   assign bus.imem_resp    = bus.imem_read && (cnt == lat - 1);
   assign bus.imem_rdata   = mem_word(bus.imem_address);
   assign bus_w.imem_resp  = bus_w.imem_read;
   assign bus_w.imem_rdata = 16'h7777;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= 0;
      else if (bus.imem_resp) cnt <= 0;
      else if (bus.imem_read) cnt <= cnt + 1;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (bus.imem_read !== 1'b0) begin errors++;
         $display("FAIL rst_read: got %b want 0", bus.imem_read); end
      checks++; if (bus.imem_address !== 16'h0000) begin errors++;
         $display("FAIL rst_addr: got %h want 0000", bus.imem_address); end
      checks++; if (if_valid !== 1'b0) begin errors++;
         $display("FAIL rst_valid: got %b want 0", if_valid); end
      checks++; if (if_opcode !== 4'h0) begin errors++;
         $display("FAIL rst_opcode: got %h want 0", if_opcode); end
      checks++; if (if_pc_plus2 !== 16'h0002) begin errors++;
         $display("FAIL rst_pc_plus2: got %h want 0002", if_pc_plus2); end
      checks++; if (if_ir !== 16'h0000 || if_pc !== 16'h0000) begin errors++;
         $display("FAIL rst_ir_pc: got %h/%h want 0000/0000", if_ir, if_pc); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++; if (bus.imem_read !== 1'b0) begin errors++;
         $display("FAIL start_read: got %b want 0", bus.imem_read); end
      step();
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0000) begin errors++;
         $display("FAIL first_read: got %b@%h want 1@0000", bus.imem_read, bus.imem_address); end
   endtask

   task automatic test_basic();
      checks++; if (if_valid !== 1'b0) begin errors++;
         $display("FAIL fetch0_valid: got %b want 0", if_valid); end
      step();
      checks++; if (if_valid !== 1'b1 || if_ir !== 16'h1234 || if_opcode !== 4'h1
                    || if_pc !== 16'h0000 || bus.imem_read !== 1'b0) begin errors++;
         $display("FAIL hold0: got v=%b ir=%h op=%h pc=%h rd=%b want 1 1234 1 0000 0",
                  if_valid, if_ir, if_opcode, if_pc, bus.imem_read); end
      step();
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0002
                    || if_valid !== 1'b0) begin errors++;
         $display("FAIL fetch1: got rd=%b a=%h v=%b want 1 0002 0",
                  bus.imem_read, bus.imem_address, if_valid); end
      step();
      checks++; if (if_valid !== 1'b1 || if_ir !== 16'h5678 || if_opcode !== 4'h5
                    || if_pc !== 16'h0002 || if_pc_plus2 !== 16'h0004) begin errors++;
         $display("FAIL hold1: got v=%b ir=%h op=%h pc=%h p2=%h want 1 5678 5 0002 0004",
                  if_valid, if_ir, if_opcode, if_pc, if_pc_plus2); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (if_valid !== 1'b1 || if_ir !== 16'h5678 || if_pc !== 16'h0002
                       || bus.imem_read !== 1'b0) begin errors++;
            $display("FAIL stall%0d: got v=%b ir=%h pc=%h rd=%b want 1 5678 0002 0",
                     i, if_valid, if_ir, if_pc, bus.imem_read); end
      end
      stall = 1'b0;
      lat = 3;
      step();
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0004
                    || if_valid !== 1'b0) begin errors++;
         $display("FAIL unstall: got rd=%b a=%h v=%b want 1 0004 0",
                  bus.imem_read, bus.imem_address, if_valid); end
   endtask

   task automatic test_latency_redirect();
      step();
      checks++; if (bus.imem_address !== 16'h0004) begin errors++;
         $display("FAIL lat_addr1: got %h want 0004", bus.imem_address); end
      redirect = 1'b1;
      redirect_pc = 16'h0100;
      step();
      redirect = 1'b0;
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0004
                    || if_valid !== 1'b0) begin errors++;
         $display("FAIL discard: got rd=%b a=%h v=%b want 1 0004 0",
                  bus.imem_read, bus.imem_address, if_valid); end
      step();
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0100
                    || if_valid !== 1'b0) begin errors++;
         $display("FAIL after_discard: got rd=%b a=%h v=%b want 1 0100 0",
                  bus.imem_read, bus.imem_address, if_valid); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (bus.imem_address !== 16'h0100 || if_valid !== 1'b0) begin errors++;
            $display("FAIL lat_stable%0d: got a=%h v=%b want 0100 0",
                     i, bus.imem_address, if_valid); end
      end
      step();
      checks++; if (if_valid !== 1'b1 || if_ir !== 16'h2100 || if_opcode !== 4'h2
                    || if_pc !== 16'h0100) begin errors++;
         $display("FAIL hold_0100: got v=%b ir=%h op=%h pc=%h want 1 2100 2 0100",
                  if_valid, if_ir, if_opcode, if_pc); end
   endtask

   task automatic test_redirect_resp();
      lat = 1;
      step();
      checks++; if (bus.imem_address !== 16'h0102 || bus.imem_resp !== 1'b1) begin errors++;
         $display("FAIL rr_fetch: got a=%h resp=%b want 0102 1",
                  bus.imem_address, bus.imem_resp); end
      redirect = 1'b1;
      redirect_pc = 16'h0200;
      step();
      redirect = 1'b0;
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0200
                    || if_valid !== 1'b0) begin errors++;
         $display("FAIL rr_refetch: got rd=%b a=%h v=%b want 1 0200 0",
                  bus.imem_read, bus.imem_address, if_valid); end
      step();
      checks++; if (if_valid !== 1'b1 || if_ir !== 16'h3200 || if_pc !== 16'h0200) begin
         errors++;
         $display("FAIL rr_hold: got v=%b ir=%h pc=%h want 1 3200 0200",
                  if_valid, if_ir, if_pc); end
   endtask

   task automatic test_hold_redirect();
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 16'h0004;
      step();
      redirect = 1'b0;
      stall = 1'b0;
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0004
                    || if_valid !== 1'b0) begin errors++;
         $display("FAIL hr_fetch: got rd=%b a=%h v=%b want 1 0004 0",
                  bus.imem_read, bus.imem_address, if_valid); end
      step();
      checks++; if (if_ir !== 16'hA004 || if_opcode !== 4'hA || if_pc !== 16'h0004
                    || if_pc_plus2 !== 16'h0006) begin errors++;
         $display("FAIL hr_hold: got ir=%h op=%h pc=%h p2=%h want A004 A 0004 0006",
                  if_ir, if_opcode, if_pc, if_pc_plus2); end
   endtask

   task automatic test_reset_mid();
      lat = 3;
      step();
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0006) begin errors++;
         $display("FAIL mid_fetch: got rd=%b a=%h want 1 0006",
                  bus.imem_read, bus.imem_address); end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_read !== 1'b0 || if_valid !== 1'b0
                    || bus.imem_address !== 16'h0000 || if_ir !== 16'h0000) begin errors++;
         $display("FAIL mid_reset: got rd=%b v=%b a=%h ir=%h want 0 0 0000 0000",
                  bus.imem_read, if_valid, bus.imem_address, if_ir); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++; if (bus_w.imem_read !== 1'b0 || bus_w.imem_address !== 16'hFFFE) begin
         errors++;
         $display("FAIL w_start: got rd=%b a=%h want 0 FFFE",
                  bus_w.imem_read, bus_w.imem_address); end
   endtask

   task automatic test_wrap();
      step();
      checks++; if (bus_w.imem_read !== 1'b1 || bus_w.imem_address !== 16'hFFFE) begin
         errors++;
         $display("FAIL w_fetch: got rd=%b a=%h want 1 FFFE",
                  bus_w.imem_read, bus_w.imem_address); end
      step();
      checks++; if (w_valid !== 1'b1 || w_pc !== 16'hFFFE || w_pc_plus2 !== 16'h0000
                    || w_ir !== 16'h7777 || w_opcode !== 4'h7) begin errors++;
         $display("FAIL w_hold: got v=%b pc=%h p2=%h ir=%h op=%h want 1 FFFE 0000 7777 7",
                  w_valid, w_pc, w_pc_plus2, w_ir, w_opcode); end
      step();
      checks++; if (bus_w.imem_read !== 1'b1 || bus_w.imem_address !== 16'h0000) begin
         errors++;
         $display("FAIL w_next: got rd=%b a=%h want 1 0000",
                  bus_w.imem_read, bus_w.imem_address); end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      stall_w     = 1'b0;
      redirect_w  = 1'b0;
      lat         = 1;
      test_reset();
      test_basic();
      test_stall();
      test_latency_redirect();
      test_redirect_resp();
      test_hold_redirect();
      test_reset_mid();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
